// File: rtl/v_alu_pipe_if.sv
// Beat-level handshake bundle between operand fetch, the vector ALU and writeback.
interface v_alu_pipe_if #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned OP_W   = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   op_instr;
    logic [1:0]        vsew;
    logic              in_first;
    logic              in_last;
    logic [DATA_W-1:0] op_A;
    logic [DATA_W-1:0] op_B;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              out_err;

    // Producer side: drives beats and accepts results.
    modport master (
        output in_valid, op_instr, vsew, in_first, in_last, op_A, op_B, out_ready,
        input  in_ready, out_valid, result, out_err
    );

    // ALU side.
    modport slave (
        input  in_valid, op_instr, vsew, in_first, in_last, op_A, op_B, out_ready,
        output in_ready, out_valid, result, out_err
    );
endinterface

// File: rtl/v_alu_pipe.sv
// Pipelined packed-SIMD vector ALU: per-element arithmetic at 8/16/32-bit element width,
// one output register with valid/ready, and multi-beat sum / signed-max reductions.
module v_alu_pipe #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned OP_W   = 4
) (
    input  logic         clk,
    input  logic         nrst,
    v_alu_pipe_if.slave  bus
);
    localparam int unsigned N8  = DATA_W / 8;
    localparam int unsigned N16 = DATA_W / 16;
    localparam int unsigned N32 = DATA_W / 32;

    localparam logic [3:0] OpAdd    = 4'd0;
    localparam logic [3:0] OpSub    = 4'd1;
    localparam logic [3:0] OpAnd    = 4'd2;
    localparam logic [3:0] OpOr     = 4'd3;
    localparam logic [3:0] OpXor    = 4'd4;
    localparam logic [3:0] OpSll    = 4'd5;
    localparam logic [3:0] OpSrl    = 4'd6;
    localparam logic [3:0] OpSra    = 4'd7;
    localparam logic [3:0] OpMin    = 4'd8;
    localparam logic [3:0] OpMax    = 4'd9;
    localparam logic [3:0] OpMinu   = 4'd10;
    localparam logic [3:0] OpMaxu   = 4'd11;
    localparam logic [3:0] OpSaddu  = 4'd12;
    localparam logic [3:0] OpSadd   = 4'd13;
    localparam logic [3:0] OpRedSum = 4'd14;
    localparam logic [3:0] OpRedMax = 4'd15;

    typedef enum logic {StIdle, StAccum} state_e;

    // One element operation. Operands arrive right-aligned in 32 bits; the element width is
    // taken from sew and everything above it is ignored. Arithmetic runs in 34 bits so that
    // saturating sums and signed compares never overflow.
    function automatic logic [31:0] lane_op(input logic [3:0] op, input logic [1:0] sew,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [33:0]        ua, ub, ur, umax, usum;
        logic signed [33:0] sa, sb, ss, smax, smin;
        logic [4:0]         sh;
        logic [31:0]        mask;
        case (sew)
            2'd0: begin
                ua   = {26'b0, a[7:0]};
                ub   = {26'b0, b[7:0]};
                sa   = $signed({{26{a[7]}}, a[7:0]});
                sb   = $signed({{26{b[7]}}, b[7:0]});
                sh   = {2'b0, b[2:0]};
                umax = 34'h0_0000_00FF;
                smax = 34'sh0_0000_007F;
                smin = -34'sh0_0000_0080;
                mask = 32'h0000_00FF;
            end
            2'd1: begin
                ua   = {18'b0, a[15:0]};
                ub   = {18'b0, b[15:0]};
                sa   = $signed({{18{a[15]}}, a[15:0]});
                sb   = $signed({{18{b[15]}}, b[15:0]});
                sh   = {1'b0, b[3:0]};
                umax = 34'h0_0000_FFFF;
                smax = 34'sh0_0000_7FFF;
                smin = -34'sh0_0000_8000;
                mask = 32'h0000_FFFF;
            end
            default: begin
                ua   = {2'b0, a};
                ub   = {2'b0, b};
                sa   = $signed({{2{a[31]}}, a});
                sb   = $signed({{2{b[31]}}, b});
                sh   = b[4:0];
                umax = 34'h0_FFFF_FFFF;
                smax = 34'sh0_7FFF_FFFF;
                smin = -34'sh0_8000_0000;
                mask = 32'hFFFF_FFFF;
            end
        endcase
        usum = ua + ub;
        ss   = sa + sb;
        case (op)
            OpAdd:   ur = usum;
            OpSub:   ur = ua - ub;
            OpAnd:   ur = ua & ub;
            OpOr:    ur = ua | ub;
            OpXor:   ur = ua ^ ub;
            OpSll:   ur = ua << sh;
            OpSrl:   ur = ua >> sh;
            OpSra:   ur = $unsigned(sa >>> sh);
            OpMin:   ur = (sa < sb) ? ua : ub;
            OpMax:   ur = (sa > sb) ? ua : ub;
            OpMinu:  ur = (ua < ub) ? ua : ub;
            OpMaxu:  ur = (ua > ub) ? ua : ub;
            OpSaddu: ur = (usum > umax) ? umax : usum;
            OpSadd:  ur = (ss > smax) ? $unsigned(smax) :
                          (ss < smin) ? $unsigned(smin) : $unsigned(ss);
            default: ur = '0;
        endcase
        return ur[31:0] & mask;
    endfunction

    logic [3:0]        op;
    logic [1:0]        sew;
    logic              accept;
    logic              is_red;
    logic [3:0]        red_op;
    logic [31:0]       lane;
    logic [DATA_W-1:0] alu_res;
    logic [31:0]       red_b0;
    logic [31:0]       red_acc;

    state_e            state_q, state_d;
    logic [31:0]       acc_q, acc_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              out_err_q, out_err_d;

    assign op     = bus.op_instr[3:0];
    assign sew    = bus.vsew;
    assign is_red = (op == OpRedSum) || (op == OpRedMax);
    assign red_op = (op == OpRedMax) ? OpMax : OpAdd;

    // Single output register: a new beat may enter whenever the held result leaves.
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.out_err   = out_err_q;

    // Element-wise ALU result for the selected element width.
    always_comb begin
        alu_res = '0;
        lane    = '0;
        case (sew)
            2'd0: begin
                for (int i = 0; i < N8; i++) begin
                    lane = lane_op(op, 2'd0, {24'b0, bus.op_A[i*8 +: 8]},
                                   {24'b0, bus.op_B[i*8 +: 8]});
                    alu_res[i*8 +: 8] = lane[7:0];
                end
            end
            2'd1: begin
                for (int i = 0; i < N16; i++) begin
                    lane = lane_op(op, 2'd1, {16'b0, bus.op_A[i*16 +: 16]},
                                   {16'b0, bus.op_B[i*16 +: 16]});
                    alu_res[i*16 +: 16] = lane[15:0];
                end
            end
            2'd2: begin
                for (int i = 0; i < N32; i++) begin
                    lane = lane_op(op, 2'd2, bus.op_A[i*32 +: 32], bus.op_B[i*32 +: 32]);
                    alu_res[i*32 +: 32] = lane;
                end
            end
            default: alu_res = '0;
        endcase
    end

    // Reduction seed (B element 0, running accumulator, or zero when IDLE without in_first)
    // folded with every element of A.
    always_comb begin
        red_b0 = '0;
        case (sew)
            2'd0:    red_b0[7:0]  = bus.op_B[7:0];
            2'd1:    red_b0[15:0] = bus.op_B[15:0];
            default: red_b0       = bus.op_B[31:0];
        endcase
        if (bus.in_first) begin
            red_acc = red_b0;
        end else if (state_q == StAccum) begin
            red_acc = acc_q;
        end else begin
            red_acc = '0;
        end
        case (sew)
            2'd0: begin
                for (int i = 0; i < N8; i++) begin
                    red_acc = lane_op(red_op, 2'd0, red_acc, {24'b0, bus.op_A[i*8 +: 8]});
                end
            end
            2'd1: begin
                for (int i = 0; i < N16; i++) begin
                    red_acc = lane_op(red_op, 2'd1, red_acc, {16'b0, bus.op_A[i*16 +: 16]});
                end
            end
            2'd2: begin
                for (int i = 0; i < N32; i++) begin
                    red_acc = lane_op(red_op, 2'd2, red_acc, bus.op_A[i*32 +: 32]);
                end
            end
            default: red_acc = red_acc;
        endcase
    end

    // Next state for the output register, accumulator and reduction FSM.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        result_d    = result_q;
        out_err_d   = out_err_q;
        if (accept) begin
            if (sew == 2'd3) begin
                // Reserved width: flag it and drop any open reduction.
                result_d    = '0;
                out_err_d   = 1'b1;
                out_valid_d = 1'b1;
                state_d     = StIdle;
                acc_d       = '0;
            end else if (is_red) begin
                acc_d = red_acc;
                if (bus.in_last) begin
                    result_d        = '0;
                    result_d[31:0]  = red_acc;
                    out_err_d       = 1'b0;
                    out_valid_d     = 1'b1;
                    state_d         = StIdle;
                end else begin
                    state_d = StAccum;
                end
            end else begin
                result_d    = alu_res;
                out_err_d   = 1'b0;
                out_valid_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            out_err_q   <= out_err_d;
        end
    end
endmodule

// File: doc/v_alu_pipe.md
Name: v_alu_pipe

Overview:
- Parametrised, pipelined successor of the single-word VALU.
- Processes DATA_W-bit vector beats, with one packed beat per transfer.
- Runtime element width is 8/16/32 bits, selected by vsew.
- Adds over the previous VALU: valid/ready handshake, unsigned min/max, saturating add, and multi-beat reductions (sum, signed max) with an internal accumulator.
- Sits between the operand-fetch stage and the vector-register writeback.

Parameters:
- DATA_W, 128: beat width in bits. Must be a multiple of 32.
- OP_W, 4: op_instr width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- nrst  in  1  reset, synchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- op_instr  in  OP_W  operation code
- vsew  in  2  element width: 0=8, 1=16, 2=32, 3=reserved
- in_first  in  1  first beat of a reduction (ignored for non-reduction ops)
- in_last  in  1  last beat of a reduction (ignored for non-reduction ops)
- op_A  in  DATA_W  vs2 operand, packed elements, element 0 at LSBs
- op_B  in  DATA_W  vs1/scalar operand, packed
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- result  out  DATA_W  packed result
- out_err  out  1  beat used reserved vsew

Behaviour:
- Handshake and pipeline
  - Clock clk; reset nrst is synchronous and active-low. Both are fixed.
  - A beat is accepted when in_valid && in_ready.
  - in_ready = !out_valid || out_ready (one output register; full throughput).
  - Non-reduction ops: result, out_err and out_valid are registered one cycle after acceptance.
  - result and out_err hold stable while out_valid && !out_ready.
- Reset: out_valid=0, result=0, out_err=0, accumulator=0, red_active=0.
  - Reset mid-reduction discards the partial accumulator. The next reduction requires in_first.
- Element count: N = DATA_W/SEW. All ops act per element, independently, with no carries across elements.
- Op codes:
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, wrap modulo 2^SEW.
  - 5 SLL, 6 SRL, 7 SRA: shift A by B[log2(SEW)-1:0] of the same element. Upper B bits are ignored.
  - 8 MIN and 9 MAX are signed. 10 MINU and 11 MAXU are unsigned.
  - 12 SADDU: unsigned saturating add, clamps to 2^SEW-1.
  - 13 SADD: signed saturating add, clamps to +2^(SEW-1)-1 / -2^(SEW-1).
  - 14 REDSUM, 15 REDMAX: reductions.
- Reductions (FSM IDLE/ACCUM)
  - Accepted beat with in_first: acc = B element 0 combined with all N elements of A. red_active=1.
  - Accepted beat in ACCUM without in_first: acc combined with all N elements of A.
  - REDSUM wraps modulo 2^SEW. REDMAX is signed.
  - Beat with in_last: result = acc zero-extended in element 0, all other bits 0. out_valid=1. Return to IDLE.
  - in_first && in_last on the same beat: single-beat reduction, output after 1 cycle.
  - Beats without in_last produce no output (out_valid unchanged by them) and are accepted whenever in_ready.
  - A reduction beat without in_first while IDLE: treated as in_first with B element 0 = 0.
  - in_first while in ACCUM: restarts, and the old accumulator is discarded.
  - vsew and op are sampled per beat; changing them mid-reduction is not supported and results are undefined.
  - Non-reduction beats may not be interleaved with an open reduction; doing so is undefined.
- Reserved vsew=3: result=0, out_err=1, out_valid follows the normal rules. Any reduction state is cleared to IDLE.
- Simultaneous out_ready and new accept: the output register reloads in the same cycle, with no bubble.

Test Plan:
- SEW8 ADD, DATA_W=128:
  - Stimulus: every byte A=0x7F, B=0x02.
  - Required: every byte 0x81. out_valid exactly 1 cycle after accept. No carry into the next byte.
- SEW16 SADD and SADDU:
  - Stimulus: elements A=0x7FF0, B=0x0020.
  - Required: SADD gives 0x7FFF. SADDU gives 0x8010.
  - Stimulus: A=0xFFF0, B=0x0020.
  - Required: SADDU gives 0xFFFF. SADD gives 0x0010.
- SEW32 SRA/SRL:
  - Stimulus: A=0x80000000, B=0x00000024 (shift 4).
  - Required: SRA gives 0xF8000000. SRL gives 0x08000000.
- REDSUM SEW8, 3 beats:
  - Stimulus: first beat B elem0=5, all A bytes 1. Then two more beats of all-1 bytes, last flagged.
  - Required: result=0x35 in byte 0, rest 0. Single out_valid pulse.
  - Wrap check: sum 300 yields 0x2C.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with in_valid held.
  - Required: in_ready=0 while out_valid. result stable. No beat lost or duplicated. Throughput 1/cycle once out_ready=1.
- Reset mid-REDMAX and reserved vsew:
  - Stimulus: nrst=0 after 2 beats, then a single first+last REDMAX with A bytes {-3,7,...}, B elem0=-128.
  - Required: result=7.
  - Stimulus: vsew=3 beat.
  - Required: result=0, out_err=1.
